// File: rtl/aes_key_sched_ctrl.sv
// Round-key schedule controller: steps keyExpansion through rounds 1..NUM_ROUNDS,
// tracks valid round keys and grants SRAM addresses to the cipher. Option: KEYSCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS     = 10,
    parameter logic [15:0] KEY_BASE_ADDR  = 16'h0000,
    parameter logic [15:0] ADDR_STRIDE    = 16'h0001,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  keys_ready,
    output logic [NUM_ROUNDS:0]   valid_mask,
    output logic [3:0]            ke_round_num,
    output logic                  ke_enable,
    input  logic                  ke_done,
    input  logic                  rk_req,
    input  logic [3:0]            rk_round,
    output logic                  rk_grant,
    output logic [15:0]           rk_addr,
    output logic                  rk_err,
    output logic                  timeout_err
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("aes_key_sched_ctrl: unsupported parameter values");
    end

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          round_cnt_q, round_cnt_d;
    logic [NUM_ROUNDS:0] valid_mask_q, valid_mask_d;
    logic [3:0]          ke_round_num_q, ke_round_num_d;
    logic                ke_enable_q, ke_enable_d;
    logic                busy_q, busy_d;
    logic                keys_ready_q, keys_ready_d;
    logic                rk_grant_q, rk_grant_d;
    logic [15:0]         rk_addr_q, rk_addr_d;
    logic                rk_err_q, rk_err_d;
    logic                served_q, served_d;
    logic [15:0]         vm_ext;
`ifdef KEYSCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    localparam logic [NUM_ROUNDS:0] MASK_R0 = {{NUM_ROUNDS{1'b0}}, 1'b1};

    always_comb begin
        state_d        = state_q;
        round_cnt_d    = round_cnt_q;
        valid_mask_d   = valid_mask_q;
        ke_round_num_d = ke_round_num_q;
        ke_enable_d    = ke_enable_q;
        rk_grant_d     = 1'b0;
        rk_addr_d      = rk_addr_q;
        rk_err_d       = 1'b0;
        served_d       = served_q;
`ifdef KEYSCHED_TIMEOUT_EN
        wd_d           = wd_q;
        timeout_err_d  = timeout_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    valid_mask_d = MASK_R0;
                    round_cnt_d  = 4'd1;
                    state_d      = S_LAUNCH;
`ifdef KEYSCHED_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            S_LAUNCH: begin
                ke_round_num_d = round_cnt_q;
                ke_enable_d    = 1'b1;
                state_d        = S_WAIT;
`ifdef KEYSCHED_TIMEOUT_EN
                wd_d           = '0;
`endif
            end
            S_WAIT: begin
                if (ke_done) begin
                    valid_mask_d = valid_mask_q | (MASK_R0 << round_cnt_q);
                    ke_enable_d  = 1'b0;
                    state_d      = S_GAP;
                end
`ifdef KEYSCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    ke_enable_d   = 1'b0;
                    round_cnt_d   = 4'd0;
                    state_d       = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                // Re-raise enable as GAP ends so keyExpansion sees exactly one low cycle.
                if (round_cnt_q == 4'(NUM_ROUNDS)) begin
                    state_d = S_DONE;
                end else begin
                    round_cnt_d    = round_cnt_q + 4'd1;
                    ke_round_num_d = round_cnt_q + 4'd1;
                    ke_enable_d    = 1'b1;
                    state_d        = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            ke_enable_d  = 1'b0;
            valid_mask_d = '0;
            round_cnt_d  = 4'd0;
`ifdef KEYSCHED_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
        end

        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_GAP);
        keys_ready_d = (state_d == S_DONE);

        // One response per request; the cipher must drop rk_req before it can be served again.
        vm_ext = 16'(valid_mask_q);
        if (!rk_req) begin
            served_d = 1'b0;
        end else if (!served_q) begin
            if (rk_round > 4'(NUM_ROUNDS)) begin
                rk_err_d = 1'b1;
                served_d = 1'b1;
            end else if (vm_ext[rk_round]) begin
                rk_grant_d = 1'b1;
                rk_addr_d  = KEY_BASE_ADDR + 16'(rk_round) * ADDR_STRIDE;
                served_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            round_cnt_q    <= 4'd0;
            valid_mask_q   <= '0;
            ke_round_num_q <= 4'd0;
            ke_enable_q    <= 1'b0;
            busy_q         <= 1'b0;
            keys_ready_q   <= 1'b0;
            rk_grant_q     <= 1'b0;
            rk_addr_q      <= 16'h0000;
            rk_err_q       <= 1'b0;
            served_q       <= 1'b0;
`ifdef KEYSCHED_TIMEOUT_EN
            wd_q           <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            round_cnt_q    <= round_cnt_d;
            valid_mask_q   <= valid_mask_d;
            ke_round_num_q <= ke_round_num_d;
            ke_enable_q    <= ke_enable_d;
            busy_q         <= busy_d;
            keys_ready_q   <= keys_ready_d;
            rk_grant_q     <= rk_grant_d;
            rk_addr_q      <= rk_addr_d;
            rk_err_q       <= rk_err_d;
            served_q       <= served_d;
`ifdef KEYSCHED_TIMEOUT_EN
            wd_q           <= wd_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign keys_ready   = keys_ready_q;
    assign valid_mask   = valid_mask_q;
    assign ke_round_num = ke_round_num_q;
    assign ke_enable    = ke_enable_q;
    assign rk_grant     = rk_grant_q;
    assign rk_addr      = rk_addr_q;
    assign rk_err       = rk_err_q;
`ifdef KEYSCHED_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: round sequencing, request path, abort and watchdog.
module tb_aes_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ke_done = 1'b0;
    logic        rk_req = 1'b0;
    logic [3:0]  rk_round = 4'd0;
    logic        busy, keys_ready, ke_enable, rk_grant, rk_err, timeout_err;
    logic [10:0] valid_mask;
    logic [3:0]  ke_round_num;
    logic [15:0] rk_addr;

    int total = 0;
    int bad = 0;
    int grant_cnt = 0;
    int err_cnt = 0;
    int kcnt = 0;
    logic hold_done = 1'b0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .keys_ready(keys_ready), .valid_mask(valid_mask),
        .ke_round_num(ke_round_num), .ke_enable(ke_enable), .ke_done(ke_done),
        .rk_req(rk_req), .rk_round(rk_round), .rk_grant(rk_grant),
        .rk_addr(rk_addr), .rk_err(rk_err), .timeout_err(timeout_err)
    );

    // keyExpansion stand-in: expansionDone pulses 4 cycles after enable rises.
    always @(posedge clk) begin
        if (ke_enable !== 1'b1) begin
            kcnt    <= 0;
            ke_done <= 1'b0;
        end else begin
            kcnt    <= kcnt + 1;
            ke_done <= (kcnt == 3) && !hold_done;
        end
    end

    always @(negedge clk) begin
        if (rk_grant === 1'b1) grant_cnt++;
        if (rk_err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic lvl);
        int n = 0;
        while (ke_enable !== lvl && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ke_enable", 32'(ke_enable), 32'(lvl));
    endtask

    // One full round: enable up with the right round number, done sets the mask bit,
    // then enable is low for exactly one cycle (or the schedule completes).
    task automatic do_round(input int r);
        int mi;
        wait_en(1'b1);
        chk("round_num", 32'(ke_round_num), 32'(r));
        chk("busy_run", 32'(busy), 32'd1);
        wait_en(1'b0);
        mi = (1 << (r + 1)) - 1;
        chk("mask_step", 32'(valid_mask), 32'(mi));
        tick();
        if (r < 10) begin
            chk("en_gap_1cyc", 32'(ke_enable), 32'd1);
        end else begin
            chk("keys_ready", 32'(keys_ready), 32'd1);
            chk("mask_full", 32'(valid_mask), 32'h7FF);
            chk("busy_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(keys_ready), 32'd0);
        chk("rst_mask", 32'(valid_mask), 32'd0);
        chk("rst_en", 32'(ke_enable), 32'd0);
        chk("rst_rn", 32'(ke_round_num), 32'd0);
        chk("rst_grant", 32'(rk_grant), 32'd0);
        chk("rst_addr", 32'(rk_addr), 32'd0);
        chk("rst_err", 32'(rk_err), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);

        // Full schedule with a round-3 request issued during round 1
        pulse_start();
        chk("start_mask", 32'(valid_mask), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        rk_req = 1'b1;
        rk_round = 4'd3;
        do_round(1);
        do_round(2);
        chk("no_early_grant", 32'(grant_cnt), 32'd0);
        do_round(3);
        chk("grant_r3", 32'(rk_grant), 32'd1);
        chk("addr_r3", 32'(rk_addr), 32'h0003);
        tick();
        chk("no_regrant", 32'(rk_grant), 32'd0);
        rk_req = 1'b0;
        for (int r = 4; r <= 10; r++) do_round(r);
        chk("grant_total1", 32'(grant_cnt), 32'd1);

        // Out-of-range requests error out, last round key grants
        rk_req = 1'b1;
        rk_round = 4'd12;
        tick();
        chk("err_r12", 32'(rk_err), 32'd1);
        chk("err_r12_nogr", 32'(rk_grant), 32'd0);
        tick();
        chk("err_once", 32'(rk_err), 32'd0);
        rk_req = 1'b0;
        tick();
        rk_req = 1'b1;
        rk_round = 4'd11;
        tick();
        chk("err_r11", 32'(rk_err), 32'd1);
        rk_req = 1'b0;
        tick();
        chk("err_total", 32'(err_cnt), 32'd2);
        rk_req = 1'b1;
        rk_round = 4'd10;
        tick();
        chk("grant_r10", 32'(rk_grant), 32'd1);
        chk("addr_r10", 32'(rk_addr), 32'h000A);
        rk_req = 1'b0;
        tick();
        chk("grant_drop", 32'(rk_grant), 32'd0);
        chk("addr_hold", 32'(rk_addr), 32'h000A);
        chk("grant_total2", 32'(grant_cnt), 32'd2);

        // Restart from DONE, abort in round-5 WAIT with a round-5 request pending
        pulse_start();
        chk("restart_mask", 32'(valid_mask), 32'd1);
        chk("restart_ready", 32'(keys_ready), 32'd0);
        for (int r = 1; r <= 4; r++) do_round(r);
        wait_en(1'b1);
        chk("r5_num", 32'(ke_round_num), 32'd5);
        rk_req = 1'b1;
        rk_round = 4'd5;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_en", 32'(ke_enable), 32'd0);
        chk("abort_mask", 32'(valid_mask), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        chk("abort_stall", 32'(grant_cnt), 32'd2);
        pulse_start();
        for (int r = 1; r <= 4; r++) do_round(r);
        chk("stall_r4", 32'(grant_cnt), 32'd2);
        do_round(5);
        chk("grant_r5", 32'(rk_grant), 32'd1);
        chk("addr_r5", 32'(rk_addr), 32'h0005);
        rk_req = 1'b0;
        for (int r = 6; r <= 10; r++) do_round(r);

        // Start+abort together in IDLE; start while busy is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_ready", 32'(keys_ready), 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_mask", 32'(valid_mask), 32'd0);
        repeat (3) tick();
        chk("sa_idle_busy", 32'(busy), 32'd0);
        chk("sa_idle_en", 32'(ke_enable), 32'd0);
        pulse_start();
        do_round(1);
        pulse_start();
        chk("busy_start_mask", 32'(valid_mask), 32'h003);
        for (int r = 2; r <= 10; r++) do_round(r);

        // Round 2 never completes
        pulse_start();
        do_round(1);
        hold_done = 1'b1;
        tick();
        repeat (63) tick();
        chk("wd_pre_tmo", 32'(timeout_err), 32'd0);
        chk("wd_pre_busy", 32'(busy), 32'd1);
        tick();
`ifdef KEYSCHED_TIMEOUT_EN
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_mask", 32'(valid_mask), 32'h003);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_en", 32'(ke_enable), 32'd0);
        hold_done = 1'b0;
        repeat (3) tick();
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        pulse_start();
        chk("tmo_clr", 32'(timeout_err), 32'd0);
`else
        chk("no_tmo_flag", 32'(timeout_err), 32'd0);
        chk("no_tmo_busy", 32'(busy), 32'd1);
        chk("no_tmo_en", 32'(ke_enable), 32'd1);
        hold_done = 1'b0;
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_mask", 32'(valid_mask), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
